// File: rtl/jk_timer_pkg.sv
// Shared types and limits for the jk_timer loadable down-counter.
`default_nettype none

package jk_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } jk_timer_state_t;

  localparam int WIDTH_MAX    = 16;
  localparam int PRESCALE_MAX = 256;

endpackage

`default_nettype wire

// File: rtl/jk_timer_prescale.sv
// Prescaler: emits one tick per PRESCALE incremented cycles; clr restarts the phase.
`default_nettype none

module jk_timer_prescale #(
  parameter int PRESCALE = 1
) (
  input  logic CLK,
  input  logic R,
  input  logic clr,
  input  logic inc,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  generate
    if (PRESCALE > 1) begin : g_div
      localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
      logic [CW-1:0] cnt;

      assign tick = inc & (cnt == LAST);

      always_ff @(posedge CLK) begin
        if (R || clr) begin
          cnt <= '0;
        end else if (inc) begin
          cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
      end
    end else begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = CLK ^ R ^ clr;
      assign tick          = inc;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/jk_timer.sv
// Loadable, cascadable down-counter with registered terminal-count pulse and
// a JK-style sticky interrupt latch (J = expiry tick, K = ACK).
`default_nettype none

module jk_timer
  import jk_timer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             EN,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             MODE,
  input  logic             ACK,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             IRQ,
  output logic             RUN
);

  jk_timer_state_t state, next_state;
  logic [WIDTH-1:0] reload;
  logic             presc_tick;
  logic             tick;
  logic             zero_tick;
  logic             presc_inc;

  assign presc_inc = EN & (state == COUNT);

  jk_timer_prescale #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .CLK  (CLK),
    .R    (R),
    .clr  (LD),
    .inc  (presc_inc),
    .tick (presc_tick)
  );

  // A load in the same cycle swallows the tick, so no TC and no IRQ set.
  assign tick      = presc_tick & ~LD;
  assign zero_tick = tick & (Q == '0);

  always_ff @(posedge CLK) begin
    if (R) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (LD) next_state = COUNT;
      COUNT: begin
        if (LD)                      next_state = COUNT;
        else if (zero_tick && !MODE) next_state = DONE;
      end
      DONE:    if (LD) next_state = COUNT;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    RUN = (state == COUNT);
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      Q      <= '0;
      reload <= '0;
    end else if (LD) begin
      Q      <= D;
      reload <= D;
    end else if (tick) begin
      if (Q != '0) begin
        Q <= Q - WIDTH'(1);
      end else if (MODE) begin
        Q <= reload;
      end
    end
  end

  // Set dominates clear so an expiry coinciding with ACK is never lost.
  always_ff @(posedge CLK) begin
    if (R) begin
      TC  <= 1'b0;
      IRQ <= 1'b0;
    end else begin
      TC <= zero_tick;
      if (zero_tick) begin
        IRQ <= 1'b1;
      end else if (ACK) begin
        IRQ <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jk_timer.sv
// Directed self-checking bench for jk_timer, PRESCALE=1 and PRESCALE=4 instances.
`default_nettype none

module tb_jk_timer;

  logic       CLK = 1'b0;
  logic       R = 1'b0, EN = 1'b0, LD = 1'b0, MODE = 1'b0, ACK = 1'b0;
  logic [7:0] D = 8'd0;

  logic [7:0] q1, q4;
  logic       tc1, irq1, run1, tc4, irq4, run4;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  jk_timer #(.WIDTH(8), .PRESCALE(1)) u_p1 (
    .CLK(CLK), .R(R), .EN(EN), .LD(LD), .D(D), .MODE(MODE), .ACK(ACK),
    .Q(q1), .TC(tc1), .IRQ(irq1), .RUN(run1)
  );

  jk_timer #(.WIDTH(8), .PRESCALE(4)) u_p4 (
    .CLK(CLK), .R(R), .EN(EN), .LD(LD), .D(D), .MODE(MODE), .ACK(ACK),
    .Q(q4), .TC(tc4), .IRQ(irq4), .RUN(run4)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    R = 1'b1; LD = 1'b0; EN = 1'b0; ACK = 1'b0;
    step();
    R = 1'b0;
  endtask

  task automatic test_reset();
    R = 1'b1; EN = 1'b1; LD = 1'b0;
    step();
    R = 1'b0;
    checks++; if ({q1, tc1, irq1, run1} !== 11'd0) begin
      errors++; $display("FAIL reset_p1: got q=%0d tc=%0b irq=%0b run=%0b expected all 0", q1, tc1, irq1, run1);
    end
    checks++; if ({q4, tc4, irq4, run4} !== 11'd0) begin
      errors++; $display("FAIL reset_p4: got q=%0d tc=%0b irq=%0b run=%0b expected all 0", q4, tc4, irq4, run4);
    end
  endtask

  task automatic test_oneshot();
    D = 8'd3; MODE = 1'b0; EN = 1'b1; LD = 1'b1;
    step();
    LD = 1'b0;
    checks++; if (q1 !== 8'd3 || run1 !== 1'b1) begin
      errors++; $display("FAIL oneshot_load: got q=%0d run=%0b expected q=3 run=1", q1, run1);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (q1 !== 8'(3 - i) || tc1 !== 1'b0) begin
        errors++; $display("FAIL oneshot_count[%0d]: got q=%0d tc=%0b expected q=%0d tc=0", i, q1, tc1, 3 - i);
      end
    end
    step();
    checks++; if (tc1 !== 1'b1 || irq1 !== 1'b1 || run1 !== 1'b0 || q1 !== 8'd0) begin
      errors++; $display("FAIL oneshot_expire: got tc=%0b irq=%0b run=%0b q=%0d expected tc=1 irq=1 run=0 q=0", tc1, irq1, run1, q1);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (tc1 !== 1'b0 || run1 !== 1'b0 || q1 !== 8'd0 || irq1 !== 1'b1) begin
        errors++; $display("FAIL oneshot_done_hold[%0d]: got tc=%0b run=%0b q=%0d irq=%0b expected tc=0 run=0 q=0 irq=1", i, tc1, run1, q1, irq1);
      end
    end
  endtask

  task automatic test_ack_alone();
    ACK = 1'b1;
    step();
    ACK = 1'b0;
    checks++; if (irq1 !== 1'b0) begin
      errors++; $display("FAIL ack_clear: got irq=%0b expected 0", irq1);
    end
  endtask

  task automatic test_autoreload();
    int pulses;
    pulses = 0;
    do_reset();
    D = 8'd2; MODE = 1'b1; EN = 1'b1; LD = 1'b1;
    step();
    LD = 1'b0;
    checks++; if (q1 !== 8'd2) begin
      errors++; $display("FAIL reload_load: got q=%0d expected 2", q1);
    end
    for (int i = 1; i <= 12; i++) begin
      step();
      if (tc1 === 1'b1) pulses++;
      checks++; if (q1 !== 8'(2 - (i % 3)) || tc1 !== (i % 3 == 0) || run1 !== 1'b1) begin
        errors++; $display("FAIL reload_seq[%0d]: got q=%0d tc=%0b run=%0b expected q=%0d tc=%0b run=1", i, q1, tc1, run1, 2 - (i % 3), (i % 3 == 0));
      end
    end
    checks++; if (pulses !== 4) begin
      errors++; $display("FAIL reload_pulses: got %0d expected 4", pulses);
    end
    // Q is 2 now: ACK alone clears, then ACK on the expiry edge loses to set.
    ACK = 1'b1;
    step();
    checks++; if (irq1 !== 1'b0 || q1 !== 8'd1) begin
      errors++; $display("FAIL reload_ack_clear: got irq=%0b q=%0d expected irq=0 q=1", irq1, q1);
    end
    ACK = 1'b0;
    step();
    ACK = 1'b1;
    step();
    ACK = 1'b0;
    checks++; if (irq1 !== 1'b1 || tc1 !== 1'b1) begin
      errors++; $display("FAIL ack_vs_set: got irq=%0b tc=%0b expected irq=1 tc=1", irq1, tc1);
    end
  endtask

  task automatic test_prescale();
    do_reset();
    D = 8'd1; MODE = 1'b0; EN = 1'b1; LD = 1'b1;
    step();
    LD = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++; if (tc4 !== (i == 8) || q4 !== ((i < 4) ? 8'd1 : 8'd0)) begin
        errors++; $display("FAIL presc_run[%0d]: got tc=%0b q=%0d expected tc=%0b q=%0d", i, tc4, q4, (i == 8), (i < 4) ? 1 : 0);
      end
    end
    checks++; if (irq4 !== 1'b1 || run4 !== 1'b0) begin
      errors++; $display("FAIL presc_expire: got irq=%0b run=%0b expected irq=1 run=0", irq4, run4);
    end
    LD = 1'b1;
    step();
    LD = 1'b0;
    step();
    step();
    EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (q4 !== 8'd1 || tc4 !== 1'b0 || run4 !== 1'b1) begin
        errors++; $display("FAIL presc_freeze[%0d]: got q=%0d tc=%0b run=%0b expected q=1 tc=0 run=1", i, q4, tc4, run4);
      end
    end
    EN = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      checks++; if (tc4 !== (i == 6) || q4 !== ((i < 2) ? 8'd1 : 8'd0)) begin
        errors++; $display("FAIL presc_resume[%0d]: got tc=%0b q=%0d expected tc=%0b q=%0d", i, tc4, q4, (i == 6), (i < 2) ? 1 : 0);
      end
    end
  endtask

  task automatic test_load_collision();
    do_reset();
    D = 8'd5; MODE = 1'b1; EN = 1'b1; LD = 1'b1;
    step();
    LD = 1'b0;
    step(); step(); step();
    checks++; if (q1 !== 8'd2) begin
      errors++; $display("FAIL ldcol_pre_p1: got q=%0d expected 2", q1);
    end
    D = 8'd7; LD = 1'b1;
    step();
    LD = 1'b0;
    checks++; if (q1 !== 8'd7 || tc1 !== 1'b0) begin
      errors++; $display("FAIL ldcol_p1: got q=%0d tc=%0b expected q=7 tc=0", q1, tc1);
    end
    // PRESCALE=4: load lands exactly on a tick edge, then phase restarts.
    do_reset();
    D = 8'd5; MODE = 1'b1; EN = 1'b1; LD = 1'b1;
    step();
    LD = 1'b0;
    for (int i = 0; i < 15; i++) step();
    checks++; if (q4 !== 8'd2) begin
      errors++; $display("FAIL ldcol_pre_p4: got q=%0d expected 2", q4);
    end
    D = 8'd7; LD = 1'b1;
    step();
    LD = 1'b0;
    checks++; if (q4 !== 8'd7 || tc4 !== 1'b0) begin
      errors++; $display("FAIL ldcol_p4: got q=%0d tc=%0b expected q=7 tc=0", q4, tc4);
    end
    step(); step(); step();
    checks++; if (q4 !== 8'd7) begin
      errors++; $display("FAIL ldcol_presc_clr: got q=%0d expected 7", q4);
    end
    step();
    checks++; if (q4 !== 8'd6) begin
      errors++; $display("FAIL ldcol_first_tick: got q=%0d expected 6", q4);
    end
  endtask

  task automatic test_reset_midcount();
    D = 8'd9; MODE = 1'b1; EN = 1'b1; LD = 1'b1;
    step();
    LD = 1'b0;
    step(); step();
    R = 1'b1;
    step();
    R = 1'b0;
    checks++; if ({q1, tc1, irq1, run1} !== 11'd0) begin
      errors++; $display("FAIL midreset: got q=%0d tc=%0b irq=%0b run=%0b expected all 0", q1, tc1, irq1, run1);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (q1 !== 8'd0 || tc1 !== 1'b0 || run1 !== 1'b0 || irq1 !== 1'b0) begin
        errors++; $display("FAIL idle_ignores_en[%0d]: got q=%0d tc=%0b run=%0b irq=%0b expected all 0", i, q1, tc1, run1, irq1);
      end
    end
  endtask

  task automatic test_continuous();
    D = 8'd0; MODE = 1'b1; EN = 1'b1; ACK = 1'b1; LD = 1'b1;
    step();
    LD = 1'b0;
    checks++; if (tc1 !== 1'b0 || irq1 !== 1'b0 || run1 !== 1'b1) begin
      errors++; $display("FAIL cont_load: got tc=%0b irq=%0b run=%0b expected tc=0 irq=0 run=1", tc1, irq1, run1);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (tc1 !== 1'b1 || irq1 !== 1'b1 || q1 !== 8'd0) begin
        errors++; $display("FAIL cont_tick[%0d]: got tc=%0b irq=%0b q=%0d expected tc=1 irq=1 q=0", i, tc1, irq1, q1);
      end
    end
    ACK = 1'b0;
  endtask

  initial begin
    step();
    test_reset();
    test_oneshot();
    test_ack_alone();
    test_autoreload();
    test_prescale();
    test_load_collision();
    test_reset_midcount();
    test_continuous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
